// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants, FSM state type and opcode helpers for the
// two-client ALU arbiter and its shared alu_always datapath.
package alu_arbiter_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] OP_ADD     = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] OP_SUB     = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] OP_AND     = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] OP_OR      = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] OP_NOT     = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] OP_XOR     = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] OP_NOR     = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] OP_SHL     = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] OP_SHR     = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] OP_ASR     = 4'b1001;
  localparam logic [ALU_CTRL_W-1:0] OP_ROL     = 4'b1010;
  localparam logic [ALU_CTRL_W-1:0] OP_ROR     = 4'b1011;
  localparam logic [ALU_CTRL_W-1:0] OP_EQ      = 4'b1100;
  localparam logic [ALU_CTRL_W-1:0] OP_RSV_MIN = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // Only add and sub produce a meaningful carry/borrow.
  function automatic logic has_carry(input logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl == OP_ADD) || (ctrl == OP_SUB);
  endfunction

  function automatic logic is_reserved(input logic [ALU_CTRL_W-1:0] ctrl);
    return ctrl >= OP_RSV_MIN;
  endfunction

endpackage

// File: rtl/alu_always.sv
// Purely combinational ALU: 4-bit opcode, W-bit operands, carry/borrow out.
// Reserved opcodes (1101-1111) produce zero.
module alu_always
  import alu_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [ALU_CTRL_W-1:0] ctrl,
  input  logic [W-1:0]          x,
  input  logic [W-1:0]          y,
  output logic [W-1:0]          out,
  output logic                  carry
);

  logic [W:0] wide;

  always_comb begin
    out   = '0;
    carry = 1'b0;
    wide  = '0;
    case (ctrl)
      OP_ADD: begin
        wide  = {1'b0, x} + {1'b0, y};
        out   = wide[W-1:0];
        carry = wide[W];
      end
      OP_SUB: begin
        // Top bit of the extended difference is the borrow.
        wide  = {1'b0, x} - {1'b0, y};
        out   = wide[W-1:0];
        carry = wide[W];
      end
      OP_AND:  out = x & y;
      OP_OR:   out = x | y;
      OP_NOT:  out = ~x;
      OP_XOR:  out = x ^ y;
      OP_NOR:  out = ~(x | y);
      OP_SHL:  out = y << x[2:0];
      OP_SHR:  out = y >> x[2:0];
      OP_ASR:  out = {x[W-1], x[W-1:1]};
      OP_ROL:  out = {x[W-2:0], x[W-1]};
      OP_ROR:  out = {x[0], x[W-1:1]};
      OP_EQ:   out = {{(W-1){1'b0}}, (x == y)};
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one alu_always between two clients:
// IDLE accepts one request, EXEC registers the result, RESP holds it until taken.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ALU_CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0]     req0_x,
  input  logic [DATA_W-1:0]     req0_y,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ALU_CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0]     req1_x,
  input  logic [DATA_W-1:0]     req1_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_out,
  output logic                  rsp_carry,
  output logic                  rsp_illegal,
  output logic [CNT_W-1:0]      grant_cnt0,
  output logic [CNT_W-1:0]      grant_cnt1
);

  state_t state_reg, state_next;
  logic   last_grant_reg;

  logic [ALU_CTRL_W-1:0] op_ctrl_reg;
  logic [DATA_W-1:0]     op_x_reg;
  logic [DATA_W-1:0]     op_y_reg;
  logic                  op_id_reg;

  logic                  rsp_valid_reg;
  logic                  rsp_id_reg;
  logic [DATA_W-1:0]     rsp_out_reg;
  logic                  rsp_carry_reg;
  logic                  rsp_illegal_reg;

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic                  accept;
  logic                  accept_id;
  logic                  release_rsp;

  logic [ALU_CTRL_W-1:0] sel_ctrl;
  logic [DATA_W-1:0]     sel_x;
  logic [DATA_W-1:0]     sel_y;

  logic [DATA_W-1:0]     alu_out;
  logic                  alu_carry;

  assign req_valid = {req1_valid, req0_valid};

  // Grant only in IDLE; on a tie the requester that did not win last time goes.
  always_comb begin
    req_ready = 2'b00;
    if (state_reg == IDLE) begin
      if (req_valid == 2'b11) begin
        req_ready = last_grant_reg ? 2'b01 : 2'b10;
      end else begin
        req_ready = req_valid;
      end
    end
  end

  assign accept      = |(req_ready & req_valid);
  assign accept_id   = req_ready[1];
  assign release_rsp = (state_reg == RESP) && rsp_valid_reg && rsp_ready;

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  always_comb begin
    sel_ctrl = req0_ctrl;
    sel_x    = req0_x;
    sel_y    = req0_y;
    if (accept_id) begin
      sel_ctrl = req1_ctrl;
      sel_x    = req1_x;
      sel_y    = req1_y;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (release_rsp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (accept) last_grant_reg <= accept_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_ctrl_reg <= '0;
      op_x_reg    <= '0;
      op_y_reg    <= '0;
      op_id_reg   <= 1'b0;
    end else if (accept) begin
      op_ctrl_reg <= sel_ctrl;
      op_x_reg    <= sel_x;
      op_y_reg    <= sel_y;
      op_id_reg   <= accept_id;
    end
  end

  alu_always #(
    .W(DATA_W)
  ) u_alu (
    .ctrl  (op_ctrl_reg),
    .x     (op_x_reg),
    .y     (op_y_reg),
    .out   (alu_out),
    .carry (alu_carry)
  );

  // Response fields are written only in EXEC, so they stay frozen through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= 1'b0;
      rsp_out_reg     <= '0;
      rsp_carry_reg   <= 1'b0;
      rsp_illegal_reg <= 1'b0;
    end else if (state_reg == EXEC) begin
      rsp_valid_reg   <= 1'b1;
      rsp_id_reg      <= op_id_reg;
      rsp_out_reg     <= alu_out;
      rsp_carry_reg   <= alu_carry & has_carry(op_ctrl_reg);
      rsp_illegal_reg <= is_reserved(op_ctrl_reg);
    end else if (release_rsp) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_out     = rsp_out_reg;
  assign rsp_carry   = rsp_carry_reg;
  assign rsp_illegal = rsp_illegal_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (req_valid[gi] && req_ready[gi]) begin
        cnt_reg <= cnt_next;
      end
    end
  end

  assign grant_cnt0 = g_cnt[0].cnt_reg;
  assign grant_cnt1 = g_cnt[1].cnt_reg;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer that shares one combinational `alu_always` instance (8-bit, 4-bit opcode) between two clients. It accepts requests over valid/ready handshakes and registers the ALU operands and result. It returns a tagged response under backpressure and keeps per-requester grant counters. It sits between the two operand-producing clients and the shared ALU.

## Interface
- `DATA_W`, default 8: operand/result width; must equal the `alu_always` width.
- `CNT_W`, default 8: width of each grant counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle when high together with valid.
- `req0_ctrl` / `req1_ctrl` in 4: ALU opcode.
- `req0_x`, `req0_y` / `req1_x`, `req1_y` in DATA_W: operands.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_id` out 1: requester that issued the response.
- `rsp_out` out DATA_W: ALU result.
- `rsp_carry` out 1: carry/borrow; valid only for add (0000) and sub (0001), forced 0 otherwise.
- `rsp_illegal` out 1: opcode was 1101–1111 (ALU returns 0).
- `grant_cnt0` / `grant_cnt1` out CNT_W: accepted requests per requester, wrapping.

## Operation
- FSM states:
  - IDLE: `reqN_ready` is driven by the arbiter.
  - EXEC: ALU evaluates the latched ctrl/x/y.
  - RESP: `rsp_*` held stable.
- Transitions:
  - IDLE→EXEC on any accept.
  - EXEC→RESP unconditionally.
  - RESP→IDLE on `rsp_valid && rsp_ready`.
- Arbitration, in IDLE only:
  - Exactly one `reqN_ready` is high, and only for a valid requester.
  - One valid requester: grant it.
  - Both valid: grant `~last_grant`.
  - `last_grant` updates on every accept.
  - Reset value of `last_grant` is 1, so requester 0 wins the first tie.
- Both `reqN_ready` are low in EXEC and RESP. Requests are never accepted while an operation is in flight.
- On accept, latch ctrl/x/y/id into the operand register. Increment `grant_cntN`; it wraps from 2^CNT_W−1 to 0.
- In EXEC, capture into the response registers:
  - `alu_always` out into `rsp_out`.
  - carry, masked, into `rsp_carry`.
  - `rsp_illegal = (ctrl >= 4'b1101)`.
  - `rsp_id`.
- ALU semantics are those of `alu_always`:
  - add, sub, and, or, not x, xor, nor.
  - y<<x[2:0], y>>x[2:0].
  - arithmetic shift right x by 1, rotate left x by 1, rotate right x by 1.
  - equality (x==y → 1).
  - reserved opcodes give 0.
- Reset values:
  - state IDLE.
  - `reqN_ready` 0 until the first cycle with a valid input (combinational from valid in IDLE).
  - `rsp_valid` 0; `rsp_id`, `rsp_out`, `rsp_carry`, `rsp_illegal` all 0.
  - `grant_cnt0`/`grant_cnt1` 0; `last_grant` 1.

## Timing
- Accept at edge E0. Response registered at E1, so `rsp_valid` is high in the cycle after E1. Minimum release at E2. Next accept at E3 at the earliest.
- Peak throughput is one op per 3 cycles.
- Backpressure: `rsp_*` is stable while `rsp_valid && !rsp_ready`. No new accept happens during this time. A requester held off keeps its valid and payload stable (requester obligation; not checked).
- Simultaneous `rsp_ready` release and new valid requests: the release happens first. The accept occurs in the next IDLE cycle, not the same cycle.
- Reset asserted mid-operation: the in-flight op is discarded and no response is produced. All outputs go to reset values asynchronously, and the counters clear.
- `reqN_ready` is combinational from `reqN_valid`, the state, and `last_grant`. There is no combinational path from `rsp_ready` to `reqN_ready`.

## Structure
- Shared package: the opcode constants `OP_ADD` … `OP_EQ`, `OP_RSV_MIN = 4'b1101`; the FSM state enum IDLE/EXEC/RESP; `ALU_CTRL_W = 4`.
- One sub-module: the existing `alu_always`, instantiated once, fed from the operand register. Arbitration and the FSM live in `alu_arbiter` itself.

## Test plan
- Requester 0 only, ctrl 0000, x=0xB5, y=0xF9 → `rsp_valid` two cycles after accept; out 0xAE, carry 1, id 0, illegal 0; `grant_cnt0`=1.
- Requester 1 only, ctrl 0001, x=0x3B, y=0x02 → out 0x39, carry 0, id 1. Then ctrl 0010 with x=0xB5, y=0x79 → out 0x31, carry forced 0.
- Both valid continuously, with req0 0111 (x=0xB5, y=0x79) and req1 1100 (x=y=0xB5), for four ops → ids 0,1,0,1. Outputs alternate 0x20 and 0x01. Counters end at 2/2.
- `rsp_ready` held low for 5 cycles after a response → `rsp_*` unchanged, both readies low, no counter change. Then ready pulses once → IDLE next cycle.
- ctrl 1110 → out 0x00, illegal 1, carry 0.
- `rst_n` pulsed low during EXEC and again during RESP → `rsp_valid` 0 immediately, no response emitted. Counters 0; the next tie goes to requester 0.
